// File: rtl/gcd_pkg.sv
// Shared types and default sizes for the GCD arbiter slice.
// Holds the sequencer state enum and the default requester count / operand width.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;

endpackage

// File: rtl/gcd_arbiter_if.sv
// Handshake bundle between clients, the arbiter and the shared GCD engine.
// master = client/engine side, slave = arbiter side.
interface gcd_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = $clog2(NREQ)
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_res;

    logic              eng_start;
    logic [W-1:0]      eng_a;
    logic [W-1:0]      eng_b;
    logic              eng_done;
    logic [W-1:0]      eng_res;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, eng_done, eng_res,
        input  req_ready, rsp_valid, rsp_id, rsp_res, eng_start, eng_a, eng_b
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, eng_done, eng_res,
        output req_ready, rsp_valid, rsp_id, rsp_res, eng_start, eng_a, eng_b
    );

endinterface

// File: rtl/gcd_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from last_grant+1 upward,
// wrapping modulo NREQ, and returns the first valid requester.
module gcd_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IDW-1:0]  last_grant_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            any_valid_o
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_valid_o = 1'b0;
        cand        = '0;
        // k = NREQ revisits last_grant itself, so a lone requester is never starved
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant_i) + k) % NREQ);
            if (!any_valid_o && req_valid_i[cand]) begin
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
                any_valid_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin sequencer sharing one GCD engine between NREQ requesters.
// Define GCD_ARB_ZERO_BYPASS_EN to answer pairs containing a zero without the engine.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic         clk,
    input  logic         rst,
    gcd_arbiter_if.slave bus,
    output logic         busy_o
);

    state_e          state_q;
    logic [IDW-1:0]  last_grant_q;
    logic [IDW-1:0]  id_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    res_q;
    logic            eng_start_q;
    logic            rsp_valid_q;
    logic            busy_q;

    logic [NREQ-1:0] pick_oh;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic            bypass;
    logic [W-1:0]    bypass_res_d;

    gcd_rr_pick #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_pick (
        .req_valid_i (bus.req_valid),
        .last_grant_i(last_grant_q),
        .grant_o     (pick_oh),
        .grant_idx_o (pick_idx),
        .any_valid_o (pick_any)
    );

    assign sel_a = bus.req_a[int'(pick_idx)*W +: W];
    assign sel_b = bus.req_b[int'(pick_idx)*W +: W];

    // With one operand zero, OR-ing yields the other operand (or 0 if both are zero)
    assign bypass_res_d = sel_a | sel_b;

`ifdef GCD_ARB_ZERO_BYPASS_EN
    assign bypass = (sel_a == '0) || (sel_b == '0);
`else
    assign bypass = 1'b0;
`endif

    // req_ready is combinational so the accept happens in the same IDLE cycle
    assign bus.req_ready = (state_q == ST_IDLE && !rst) ? pick_oh : '0;

    assign bus.eng_start = eng_start_q;
    assign bus.eng_a     = a_q;
    assign bus.eng_b     = b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_res   = res_q;
    assign busy_o        = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            eng_start_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        a_q          <= sel_a;
                        b_q          <= sel_b;
                        id_q         <= pick_idx;
                        last_grant_q <= pick_idx;
                        busy_q       <= 1'b1;
                        if (bypass) begin
                            res_q       <= bypass_res_d;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            eng_start_q <= 1'b1;
                            state_q     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    eng_start_q <= 1'b0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.eng_done) begin
                        res_q       <= bus.eng_res;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
